// File: rtl/prga_pkg.sv
// Shared definitions for the RC4 PRGA encrypt/decrypt blocks: byte type,
// buffer layout constant and FSM state encoding.
package prga_pkg;

  typedef logic [7:0] byte_t;

  // Length prefix lives at offset 0 of both plaintext and ciphertext buffers.
  localparam byte_t LEN_ADDR = 8'h00;

  typedef logic [3:0] state_t;

  localparam state_t IDLE    = 4'd0;
  localparam state_t LEN_REQ = 4'd1;
  localparam state_t LEN_GET = 4'd2;
  localparam state_t SI_REQ  = 4'd3;
  localparam state_t SI_GET  = 4'd4;
  localparam state_t SJ_REQ  = 4'd5;
  localparam state_t SJ_GET  = 4'd6;
  localparam state_t SWAP_I  = 4'd7;
  localparam state_t PAD_REQ = 4'd8;
  localparam state_t PAD_GET = 4'd9;

endpackage

// File: rtl/prga_enc.sv
// RC4 keystream encryptor: reads a length-prefixed plaintext buffer, runs PRGA
// on a KSA-initialised S memory and writes the length-prefixed ciphertext.
module prga_enc
  import prga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: en is sampled only on an edge where rdy=1; that edge starts a
  // run and rdy drops for the whole run. en while rdy=0 has no effect.
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren,
  output logic [3:0] dbg_state
);

  state_t state;
  byte_t  i, j, k, len, si, sj, ptb;

  assign rdy       = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      ptb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            i     <= '0;
            j     <= '0;
            k     <= 8'd1;
            state <= LEN_REQ;
          end
        end
        LEN_REQ: state <= LEN_GET;
        LEN_GET: begin
          len <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            state <= IDLE;
          end else begin
            i     <= 8'd1;
            state <= SI_REQ;
          end
        end
        SI_REQ: state <= SI_GET;
        SI_GET: begin
          si    <= s_rddata;
          ptb   <= pt_rddata;
          j     <= j + s_rddata;
          state <= SJ_REQ;
        end
        SJ_REQ: state <= SJ_GET;
        SJ_GET: begin
          sj    <= s_rddata;
          state <= SWAP_I;
        end
        SWAP_I:  state <= PAD_REQ;
        PAD_REQ: state <= PAD_GET;
        PAD_GET: begin
          if (k == len) begin
            state <= IDLE;
          end else begin
            k     <= k + 8'd1;
            i     <= i + 8'd1;
            state <= SI_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory ports are pure decodes of the current state; anything not used
  // by a state stays at zero.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      LEN_REQ: pt_addr = LEN_ADDR;
      LEN_GET: begin
        ct_addr   = LEN_ADDR;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      SI_REQ: begin
        s_addr  = i;
        pt_addr = k;
      end
      SJ_REQ: s_addr = j;
      SJ_GET: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      SWAP_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
      end
      // After the swap, S[i]+S[j] is the same sum as the latched si+sj.
      PAD_REQ: s_addr = si + sj;
      PAD_GET: begin
        ct_addr   = k;
        ct_wrdata = s_rddata ^ ptb;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_enc.sv
// Bench for prga_enc: memory models, software RC4 reference, ct-write
// scoreboard, latency/handshake/reset scenarios.
module tb_prga_enc;
  import prga_pkg::*;

  logic       clk, rst_n, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       s_wren, ct_wren;
  logic [3:0] dbg_state;

  prga_enc dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories ----------------
  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] m_s    [256];
  logic [7:0] key    [16];
  logic [7:0] orig_pt[256];

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren)  s_mem[s_addr]   = s_wrdata;
    if (ct_wren) ct_mem[ct_addr] = ct_wrdata;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int s_wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && s_wren) s_wr_cnt++;
    if (rst_n && ct_wren) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ct_unexpected: got write %0h<=%0h expected none", ct_addr, ct_wrdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("ct_write", {16'h0, ct_addr, ct_wrdata}, {16'h0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic init_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic ksa(input int keylen);
    logic [7:0] jj, t;
    init_identity();
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + s_mem[x] + key[x % keylen];
      t = s_mem[x]; s_mem[x] = s_mem[jj]; s_mem[jj] = t;
    end
  endtask

  task automatic sync_model();
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
  endtask

  // Textbook RC4 PRGA over the model S copy; expected ct writes go to exp_q.
  task automatic model_run(input int len);
    logic [7:0] ii, jj, t, pad;
    exp_q.push_back({8'h00, 8'(len)});
    jj = 0;
    for (int kk = 1; kk <= len; kk++) begin
      ii = 8'(kk);
      jj = jj + m_s[ii];
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      pad = m_s[8'(m_s[ii] + m_s[jj])];
      exp_q.push_back({8'(kk), pt_mem[kk] ^ pad});
    end
  endtask

  task automatic check_s_final(input string name);
    int diffs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) diffs++;
    check(name, diffs, 0);
  endtask

  task automatic fill_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- driver ----------------
  // Wait (bounded) for rdy; optionally wiggle en randomly while busy.
  task automatic wait_rdy(input bit toggle, output int cnt);
    cnt = 0;
    while (!rdy && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (!rdy) en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      else      en = 1'b0;
    end
  endtask

  task automatic run_enc(input int len, input bit toggle, input string tag);
    int cnt;
    model_run(len);
    s_wr_cnt = 0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
    wait_rdy(toggle, cnt);
    en = 1'b0;
    check({tag, "_latency"}, cnt, 2 + 7 * len);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check_s_final({tag, "_s_final"});
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int diffs;
    rst_n = 1'b0;
    en    = 1'b0;
    init_identity();
    for (int x = 0; x < 256; x++) begin pt_mem[x] = 0; ct_mem[x] = 0; end
    #1;
    check("reset_rdy", rdy, 1);
    check("reset_state", dbg_state, IDLE);
    check("reset_outs", {s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Identity S, two-byte message
    init_identity(); sync_model();
    pt_mem[0] = 8'h02; pt_mem[1] = 8'h41; pt_mem[2] = 8'h42;
    run_enc(2, 1'b0, "ident");
    check("ident_ct0", ct_mem[0], 8'h02);
    check("ident_ct1", ct_mem[1], 8'h43);
    check("ident_ct2", ct_mem[2], 8'h47);
    check("ident_s2", s_mem[2], 8'h03);
    check("ident_s3", s_mem[3], 8'h02);

    // Empty message: one ct write, no S writes
    init_identity(); sync_model();
    pt_mem[0] = 8'h00;
    run_enc(0, 1'b0, "empty");
    check("empty_s_wren", s_wr_cnt, 0);

    // i==j collision
    init_identity(); s_mem[1] = 8'h00; sync_model();
    fill_pt(6);
    run_enc(6, 1'b0, "collide");
    check("collide_s1", s_mem[1], 8'h00);

    // Random keys, short messages, en wiggling while busy
    for (int r = 0; r < 4; r++) begin
      for (int x = 0; x < 16; x++) key[x] = 8'($urandom_range(0, 255));
      ksa(16); sync_model();
      fill_pt($urandom_range(1, 20));
      run_enc(int'(pt_mem[0]), 1'b1, "rand");
    end

    // Round trip on a full-length buffer
    for (int x = 0; x < 16; x++) key[x] = 8'($urandom_range(0, 255));
    fill_pt(255);
    for (int x = 0; x < 256; x++) orig_pt[x] = pt_mem[x];
    ksa(8); sync_model();
    run_enc(255, 1'b0, "rt_enc");
    for (int x = 0; x < 256; x++) pt_mem[x] = ct_mem[x];
    ksa(8); sync_model();
    run_enc(255, 1'b1, "rt_dec");
    diffs = 0;
    for (int x = 0; x < 256; x++) if (ct_mem[x] !== orig_pt[x]) diffs++;
    check("rt_recovered", diffs, 0);

    // en held high: back-to-back runs with a single rdy cycle between
    init_identity(); sync_model();
    fill_pt(3);
    model_run(3);
    model_run(3);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!rdy && cnt < 3000) begin @(negedge clk); cnt++; end
    check("b2b_lat1", cnt, 2 + 7 * 3);
    @(negedge clk);
    check("b2b_gap", rdy, 0);
    cnt = 0;
    while (!rdy && cnt < 3000) begin @(negedge clk); cnt++; end
    en = 1'b0;
    check("b2b_lat2", cnt, 2 + 7 * 3);
    check("b2b_q_empty", exp_q.size(), 0);
    check_s_final("b2b_s_final");
    exp_q.delete();

    // Reset during SJ_GET of byte 3
    for (int x = 0; x < 16; x++) key[x] = 8'($urandom_range(0, 255));
    ksa(16); sync_model();
    fill_pt(5);
    model_run(5);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    while (cnt < 19 && !rdy) begin @(negedge clk); cnt++; end
    check("rst_at_sj_get", dbg_state, SJ_GET);
    rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy, 1);
    check("rst_wren", {s_wren, ct_wren}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ksa(16); sync_model();
    run_enc(5, 1'b0, "post_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
